// File: rtl/cpu7_ifu_iresp_pkg.sv
// Shared constants and types for the cpu7 instruction-fetch responder.
// Holds the ADEF exception code, the fetch data width, the tag layout
// stored per accepted request, and the DEPTH-derived counter width helper.
package cpu7_ifu_iresp_pkg;

  localparam int GRLEN = 32;

  // Fetch address error exception code
  localparam logic [5:0] EXC_ADEF = 6'h08;

  // Per-request tag; the ex bit exists only when the alignment check is built
`ifdef CPU7_IRESP_ALIGN_CHK_EN
  typedef struct packed {
    logic ex;
    logic uc;
  } iresp_tag_t;
`else
  typedef struct packed {
    logic uc;
  } iresp_tag_t;
`endif

  // Width of a counter that must hold values 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cpu7_iresp_fifo.sv
// Synchronous tag FIFO for the instruction-fetch responder. One entry per
// accepted fetch request, retired in order. Flush empties it in one cycle.
module cpu7_iresp_fifo
  import cpu7_ifu_iresp_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  iresp_tag_t    push_tag,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output iresp_tag_t    head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  iresp_tag_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy update; flush wins over push/pop
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Tag storage write
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; the pointers and count decide which entries are live.
    if (push && !flush) mem[wr_ptr] <= push_tag;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/cpu7_ifu_iresp.sv
// cpu7 instruction-fetch responder: slave end of the IFU fetch interface.
// Accepts pipelined fetches, forwards them to an in-order variable-latency
// RAM port and returns data (or ADEF exceptions) to the IFU in request order,
// dropping responses of requests killed by inst_cancel.
// Build option: define CPU7_IRESP_ALIGN_CHK_EN to enable the misaligned-fetch
// check and ADEF reporting; without it every fetch goes to the RAM word
// address and inst_ex/inst_exccode read as 0.
module cpu7_ifu_iresp
  import cpu7_ifu_iresp_pkg::*;
#(
  parameter int         DEPTH     = 2,
  parameter logic [3:0] UC_REGION = 4'hA
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  input  logic             inst_cancel,
  output logic             inst_addr_ok,
  output logic             inst_valid_f,
  output logic [GRLEN-1:0] inst_rdata_f,
  output logic [1:0]       inst_count,
  output logic             inst_ex,
  output logic [5:0]       inst_exccode,
  output logic             inst_uncache,
  output logic             ram_req,
  output logic [31:0]      ram_addr,
  input  logic             ram_gnt,
  input  logic             ram_rvalid,
  input  logic [31:0]      ram_rdata
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] ram_pending;
  logic [CW-1:0] disc_cnt;
  logic          fifo_empty;
  logic          full;
  logic          misaligned;
  logic          uc;
  logic          issue;
  logic          accept;
  logic          rvalid_drop;
  logic          head_ex;
  logic          pop_ex;
  logic          pop_data;
  logic          pop;
  iresp_tag_t    push_tag;
  iresp_tag_t    head_tag;

`ifdef CPU7_IRESP_ALIGN_CHK_EN
  assign misaligned  = |inst_addr[1:0];
  assign head_ex     = head_tag.ex;
  assign push_tag.ex = misaligned;
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^inst_addr[1:0];
  assign misaligned     = 1'b0;
  assign head_ex        = 1'b0;
`endif

  assign uc          = (inst_addr[31:28] == UC_REGION);
  assign push_tag.uc = uc;

  // Request side: cancel and a full FIFO/RAM window both block acceptance
  assign full         = (fifo_cnt == CW'(DEPTH)) || (ram_pending == CW'(DEPTH));
  assign ram_req      = inst_req & ~full & ~inst_cancel & ~misaligned;
  assign ram_addr     = {inst_addr[31:2], 2'b00};
  assign issue        = ram_req & ram_gnt;
  assign accept       = misaligned ? (inst_req & ~full & ~inst_cancel) : issue;
  assign inst_addr_ok = accept;

  // Retire side: a RAM return is dropped while discards are owed or during cancel.
  // An ex head pops before any later read can return, which holds for DEPTH=2.
  assign rvalid_drop = inst_cancel | (disc_cnt != '0);
  assign pop_ex      = ~inst_cancel & ~fifo_empty & head_ex;
  assign pop_data    = ram_rvalid & ~rvalid_drop & ~fifo_empty & ~head_ex;
  assign pop         = pop_ex | pop_data;

  cpu7_iresp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (push_tag),
    .pop      (pop),
    .flush    (inst_cancel),
    .count    (fifo_cnt),
    .empty    (fifo_empty),
    .head     (head_tag)
  );

  // Outstanding RAM reads and reads owed to the discard path
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_pending <= '0;
      disc_cnt    <= '0;
    end else begin
      ram_pending <= ram_pending + CW'(issue)
                   - CW'(ram_rvalid && (ram_pending != '0));
      if (inst_cancel) begin
        disc_cnt <= ram_pending - CW'(ram_rvalid && (ram_pending != '0));
      end else if (ram_rvalid && (disc_cnt != '0)) begin
        disc_cnt <= disc_cnt - CW'(1);
      end
    end
  end

  // Response register: one-cycle pulse per retired FIFO head
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inst_valid_f <= 1'b0;
      inst_count   <= 2'd0;
      inst_uncache <= 1'b0;
      inst_rdata_f <= '0;
    end else begin
      inst_valid_f <= pop;
      inst_count   <= pop ? 2'd1 : 2'd0;
      inst_uncache <= pop & head_tag.uc;
      inst_rdata_f <= pop_data ? GRLEN'(ram_rdata) : '0;
    end
  end

`ifdef CPU7_IRESP_ALIGN_CHK_EN
  // Exception fields registered alongside the response
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inst_ex      <= 1'b0;
      inst_exccode <= 6'h00;
    end else begin
      inst_ex      <= pop_ex;
      inst_exccode <= pop_ex ? EXC_ADEF : 6'h00;
    end
  end
`else
  assign inst_ex      = 1'b0;
  assign inst_exccode = 6'h00;
`endif

endmodule
